lift_call_scheduler: RTL and testbench

Collects hall calls (passenger on a floor) and cabin calls (floor buttons inside the car) into a pending-call register. Selects the next target floor with a SCAN (direction-preserving) policy and hands it to the lift movement unit over a valid/ready command interface. Sequences the door-open dwell after each arrival. Sits between the button inputs and the Lift datapath, which reports the current floor and arrival.

---
 rtl/lift_call_scheduler_if.sv | 17 +
 rtl/lift_call_scheduler.sv | 158 +++++++++++++++
 tb/tb_lift_call_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_call_scheduler_if.sv
// Purpose: target-floor command channel from the call scheduler to the lift movement unit.
// Latency: pure wiring, no storage.
// Backpressure: cmd_rdy low holds cmd_vld/cmd_floor stable at the master.
//
// Ports (modports):
//   master : drives cmd_vld, cmd_floor; samples cmd_rdy   (scheduler side)
//   slave  : samples cmd_vld, cmd_floor; drives cmd_rdy   (lift side)
interface lift_call_scheduler_if #(
  parameter int FW = 3
);
  logic          cmd_vld;
  logic [FW-1:0] cmd_floor;
  logic          cmd_rdy;

  modport master (output cmd_vld, output cmd_floor, input cmd_rdy);
  modport slave  (input cmd_vld, input cmd_floor, output cmd_rdy);
endinterface

// File: rtl/lift_call_scheduler.sv
// Purpose: collects hall/cabin calls, picks the next floor with a SCAN sweep, sequences door dwell.
// Latency: call -> pending bit 1 cycle; pending -> cmd_vld 1 further cycle when idle.
// Backpressure: cmd_vld/cmd_floor held until cmd_rdy; calls keep accumulating meanwhile.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   hall_call_vld/_floor              hall call strobe and floor
//   cab_call_vld/_floor               cabin button strobe and floor
//   cur_floor, arrive_i               car position and arrival pulse from the lift
//   cmd_if (master)                   cmd_vld / cmd_floor / cmd_rdy command channel
//   pending, dir_up, door_open        call bitmap, sweep direction, door dwell
module lift_call_scheduler #(
  parameter int N_FLOORS    = 8,
  parameter int FW          = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hall_call_vld,
  input  logic [FW-1:0]         hall_call_floor,
  input  logic                  cab_call_vld,
  input  logic [FW-1:0]         cab_call_floor,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  arrive_i,
  lift_call_scheduler_if.master cmd_if,
  output logic [N_FLOORS-1:0]   pending,
  output logic                  dir_up,
  output logic                  door_open
);

  localparam int            CW         = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, MOVING, DOOR} state_t;

  state_t              state_q, state_d;
  logic [N_FLOORS-1:0] pending_q, pending_d;
  logic                dir_up_q, dir_up_d;
  logic [FW-1:0]       cmd_floor_q, cmd_floor_d;
  logic [CW-1:0]       dwell_q, dwell_d;

  logic [N_FLOORS-1:0] set_mask, clr_mask, absorb_mask;
  logic [N_FLOORS-1:0] here_mask, cmd_mask, above, below;
  logic [FW-1:0]       lo_above, hi_below;

  // One-hot decode of call floors, car position and current target. Floors
  // outside 0..N_FLOORS-1 never match any bit, so they are dropped here.
  always_comb begin
    set_mask  = '0;
    here_mask = '0;
    cmd_mask  = '0;
    above     = '0;
    below     = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (hall_call_vld && (hall_call_floor == FW'(i))) set_mask[i] = 1'b1;
      if (cab_call_vld  && (cab_call_floor  == FW'(i))) set_mask[i] = 1'b1;
      here_mask[i] = (cur_floor == FW'(i));
      cmd_mask[i]  = (cmd_floor_q == FW'(i));
      above[i]     = pending_q[i] && (FW'(i) > cur_floor);
      below[i]     = pending_q[i] && (FW'(i) < cur_floor);
    end
  end

  // Nearest pending floor on each side of the car.
  always_comb begin
    lo_above = '0;
    hi_below = '0;
    for (int i = N_FLOORS - 1; i >= 0; i--) begin
      if (above[i]) lo_above = FW'(i);
    end
    for (int i = 0; i < N_FLOORS; i++) begin
      if (below[i]) hi_below = FW'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    cmd_floor_d = cmd_floor_q;
    dwell_d     = dwell_q;
    clr_mask    = '0;
    unique case (state_q)
      IDLE: begin
        if (|(pending_q & here_mask)) begin
          // Already at a called floor: open the door without a move.
          clr_mask = here_mask;
          dwell_d  = '0;
          state_d  = DOOR;
        end else if (|pending_q) begin
          // SCAN: keep sweeping while there is work ahead, else reverse.
          state_d = ISSUE;
          if (dir_up_q) begin
            if (|above) begin
              cmd_floor_d = lo_above;
            end else begin
              cmd_floor_d = hi_below;
              dir_up_d    = 1'b0;
            end
          end else begin
            if (|below) begin
              cmd_floor_d = hi_below;
            end else begin
              cmd_floor_d = lo_above;
              dir_up_d    = 1'b1;
            end
          end
        end
      end
      ISSUE: begin
        if (cmd_if.cmd_rdy) state_d = MOVING;
      end
      MOVING: begin
        if (arrive_i) begin
          clr_mask = cmd_mask;
          dwell_d  = '0;
          state_d  = DOOR;
        end
      end
      DOOR: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = IDLE;
        end else begin
          dwell_d = dwell_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A call for the floor the door is open at is served by this stop.
  assign absorb_mask = (state_q == DOOR) ? here_mask : '0;
  // Clear is applied last so an arrival beats a same-cycle call for that floor.
  assign pending_d   = (pending_q | (set_mask & ~absorb_mask)) & ~clr_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      dir_up_q    <= 1'b1;
      cmd_floor_q <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      cmd_floor_q <= cmd_floor_d;
      dwell_q     <= dwell_d;
    end
  end

  assign cmd_if.cmd_vld   = (state_q == ISSUE);
  assign cmd_if.cmd_floor = cmd_floor_q;
  assign pending          = pending_q;
  assign dir_up           = dir_up_q;
  assign door_open        = (state_q == DOOR);

endmodule

// File: tb/tb_lift_call_scheduler.sv
// Purpose: directed stimulus for lift_call_scheduler with a floor-distance SCAN model.
// Latency: model predicts the registered outputs after every rising edge.
// Backpressure: bench plays the lift and drives cmd_rdy / arrive_i.
module tb_lift_call_scheduler;

  localparam int N    = 8;
  localparam int FW   = 4;  // wide enough to present out-of-range floors
  localparam int DOOR = 4;

  typedef logic [N-1:0] pend_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          hall_vld, cab_vld, arrive;
  logic [FW-1:0] hall_floor, cab_floor, cur_floor;
  pend_t         pending;
  logic          dir_up, door_open;

  lift_call_scheduler_if #(.FW(FW)) cmd_if ();

  lift_call_scheduler #(.N_FLOORS(N), .FW(FW), .DOOR_CYCLES(DOOR)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hall_call_vld   (hall_vld),
    .hall_call_floor (hall_floor),
    .cab_call_vld    (cab_vld),
    .cab_call_floor  (cab_floor),
    .cur_floor       (cur_floor),
    .arrive_i        (arrive),
    .cmd_if          (cmd_if),
    .pending         (pending),
    .dir_up          (dir_up),
    .door_open       (door_open)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  pend_t m_pend;
  bit    m_up, m_cmd, m_moving;
  int    m_tgt, m_door_left;

  function automatic bit has(input pend_t p, input int f);
    pend_t t;
    t = p >> f;
    return t[0];
  endfunction

  // Nearest call in the sweep direction; if none, nearest call the other way.
  function automatic int pick(input pend_t p, input int cur, input bit up, output bit nup);
    int f;
    nup = up;
    for (int d = 1; d < N; d++) begin
      f = up ? cur + d : cur - d;
      if (f >= 0 && f < N && has(p, f)) return f;
    end
    nup = !up;
    for (int d = 1; d < N; d++) begin
      f = up ? cur - d : cur + d;
      if (f >= 0 && f < N && has(p, f)) return f;
    end
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    pend_t nxt;
    int    cur;
    bit    nup;
    if (!rst_n) begin
      m_pend = '0; m_up = 1'b1; m_cmd = 1'b0; m_moving = 1'b0;
      m_tgt = 0; m_door_left = 0;
    end else begin
      nxt = m_pend;
      cur = int'(cur_floor);
      if (hall_vld && int'(hall_floor) < N && !(m_door_left > 0 && int'(hall_floor) == cur))
        nxt = nxt | (pend_t'(1) << int'(hall_floor));
      if (cab_vld && int'(cab_floor) < N && !(m_door_left > 0 && int'(cab_floor) == cur))
        nxt = nxt | (pend_t'(1) << int'(cab_floor));
      if (m_door_left > 0) begin
        m_door_left--;
      end else if (m_cmd) begin
        if (cmd_if.cmd_rdy) begin m_cmd = 1'b0; m_moving = 1'b1; end
      end else if (m_moving) begin
        if (arrive) begin
          nxt = nxt & ~(pend_t'(1) << m_tgt);
          m_moving = 1'b0; m_door_left = DOOR;
        end
      end else if (m_pend != '0) begin
        if (cur < N && has(m_pend, cur)) begin
          nxt = nxt & ~(pend_t'(1) << cur);
          m_door_left = DOOR;
        end else begin
          m_tgt = pick(m_pend, cur, m_up, nup);
          m_up  = nup;
          m_cmd = 1'b1;
        end
      end
      m_pend = nxt;
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    check("pending",   int'(pending),          int'(m_pend));
    check("dir_up",    int'(dir_up),           int'(m_up));
    check("cmd_vld",   int'(cmd_if.cmd_vld),   int'(m_cmd));
    check("cmd_floor", int'(cmd_if.cmd_floor), m_tgt);
    check("door_open", int'(door_open),        int'(m_door_left > 0));
    check("excl",      int'(door_open && cmd_if.cmd_vld), 0);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cmd(input string nm);
    int k;
    k = 0;
    while (!cmd_if.cmd_vld && k < 40) begin tick(1); k++; end
    check(nm, int'(cmd_if.cmd_vld), 1);
  endtask

  task automatic serve(output int f, output bit d);
    wait_cmd("serve_wait");
    f = int'(cmd_if.cmd_floor);
    d = dir_up;
    cmd_if.cmd_rdy = 1'b1; tick(1); cmd_if.cmd_rdy = 1'b0;
    tick(2);
    cur_floor = FW'(f); arrive = 1'b1; tick(1); arrive = 1'b0;
  endtask

  int  f0, f1, f2, door_cnt, cmd_seen;
  bit  d0, d1, d2;

  initial begin
    rst_n = 1'b0; hall_vld = 1'b0; cab_vld = 1'b0; arrive = 1'b0;
    hall_floor = '0; cab_floor = '0; cur_floor = '0; cmd_if.cmd_rdy = 1'b0;
    tick(2);
    check("rst_pending", int'(pending), 0);
    check("rst_dir_up",  int'(dir_up), 1);
    check("rst_cmd_vld", int'(cmd_if.cmd_vld), 0);
    check("rst_door",    int'(door_open), 0);
    rst_n = 1'b1; tick(1);

    // 1: single cabin call to floor 5, car at 0
    cab_vld = 1'b1; cab_floor = 4'd5; tick(1); cab_vld = 1'b0;
    check("t1_pending", int'(pending), 32'h20);
    check("t1_vld_early", int'(cmd_if.cmd_vld), 0);
    tick(1);
    check("t1_cmd_vld", int'(cmd_if.cmd_vld), 1);
    check("t1_cmd_floor", int'(cmd_if.cmd_floor), 5);
    cmd_if.cmd_rdy = 1'b1; tick(1); cmd_if.cmd_rdy = 1'b0;
    check("t1_vld_drop", int'(cmd_if.cmd_vld), 0);
    tick(2);
    cur_floor = 4'd5; arrive = 1'b1; tick(1); arrive = 1'b0;
    check("t1_cleared", int'(pending), 0);
    door_cnt = int'(door_open);
    // 2 setup: while the door is open, car reported at 3, calls {1,6,4}
    cur_floor = 4'd3;
    hall_vld = 1'b1; hall_floor = 4'd1; cab_vld = 1'b1; cab_floor = 4'd6;
    tick(1); door_cnt += int'(door_open);
    hall_vld = 1'b0; cab_floor = 4'd4;
    tick(1); door_cnt += int'(door_open);
    cab_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(1); door_cnt += int'(door_open); end
    check("t1_door_cycles", door_cnt, 4);

    // 2: SCAN order
    serve(f0, d0); serve(f1, d1); serve(f2, d2);
    check("t2_first",  f0, 4);
    check("t2_second", f1, 6);
    check("t2_third",  f2, 1);
    check("t2_dir_at6", int'(d1), 1);
    check("t2_dir_at1", int'(d2), 0);
    tick(6);

    // 3: hall+cab call for the car's own floor
    cur_floor = 4'd2;
    hall_vld = 1'b1; hall_floor = 4'd2; cab_vld = 1'b1; cab_floor = 4'd2;
    tick(1); hall_vld = 1'b0; cab_vld = 1'b0;
    door_cnt = 0; cmd_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      door_cnt += int'(door_open);
      cmd_seen += int'(cmd_if.cmd_vld);
    end
    check("t3_door_cycles", door_cnt, 4);
    check("t3_no_cmd", cmd_seen, 0);
    check("t3_pending", int'(pending), 0);

    // 4: backpressure in ISSUE; sweep reverses to up for floor 5
    cab_vld = 1'b1; cab_floor = 4'd5; tick(1); cab_vld = 1'b0;
    wait_cmd("t4_wait");
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin hall_vld = 1'b1; hall_floor = 4'd0; cab_vld = 1'b1; cab_floor = 4'd7; end
      if (i == 3) begin hall_vld = 1'b0; cab_vld = 1'b0; end
      if (i == 5) begin cur_floor = 4'd5; arrive = 1'b1; end   // must be ignored
      if (i == 6) begin cur_floor = 4'd2; arrive = 1'b0; end
      tick(1);
      check("t4_hold_vld", int'(cmd_if.cmd_vld), 1);
      check("t4_hold_floor", int'(cmd_if.cmd_floor), 5);
    end
    check("t4_pending", int'(pending), 32'hA1);
    cmd_if.cmd_rdy = 1'b1; tick(1); cmd_if.cmd_rdy = 1'b0;

    // 5: out-of-range floor, then arrival racing a call for the target
    hall_vld = 1'b1; hall_floor = 4'd9; tick(1); hall_vld = 1'b0;
    check("t5_floor9", int'(pending), 32'hA1);
    cur_floor = 4'd5; arrive = 1'b1; cab_vld = 1'b1; cab_floor = 4'd5;
    tick(1); arrive = 1'b0; cab_vld = 1'b0;
    check("t5_clear_wins", int'(pending), 32'h81);

    // 6: async reset while MOVING with pending 0x81
    wait_cmd("t6_wait");
    check("t6_target", int'(cmd_if.cmd_floor), 7);
    cmd_if.cmd_rdy = 1'b1; tick(1); cmd_if.cmd_rdy = 1'b0;
    check("t6_pending", int'(pending), 32'h81);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_dir",     int'(dir_up), 1);
    check("t6_rst_vld",     int'(cmd_if.cmd_vld), 0);
    check("t6_rst_floor",   int'(cmd_if.cmd_floor), 0);
    check("t6_rst_door",    int'(door_open), 0);
    tick(2);
    rst_n = 1'b1; cur_floor = 4'd0; tick(1);
    cab_vld = 1'b1; cab_floor = 4'd3; tick(1); cab_vld = 1'b0;
    tick(1);
    check("t6_post_rst_floor", int'(cmd_if.cmd_floor), 3);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
